// File: rtl/job_seq_beat_pack.sv
// Packs 64-bit sequence words into SEQ_PER_BEAT-lane output beats; a partial beat is closed at every end-of-job word.
// Free-running sequence/job counters are provided for status readout.
//
// state   | meaning
// ST_FILL | accumulator accepting sequences (in_ready=1)
// ST_HOLD | completed beat parked in accumulator, waiting for the output slot
module job_seq_beat_pack #(
  parameter int SEQ_PER_BEAT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [63:0]                in_seq,
  input  logic                       in_end_of_job,
  input  logic                       in_delim,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [64*SEQ_PER_BEAT-1:0] out_data,
  output logic [SEQ_PER_BEAT-1:0]    out_keep,
  output logic                       out_last,
  output logic                       out_delim,
  input  logic                       out_ready,
  output logic [31:0]                stat_seq_count,
  output logic [15:0]                stat_job_count
);

  localparam int CW = $clog2(SEQ_PER_BEAT);
  localparam int DW = 64 * SEQ_PER_BEAT;

  typedef enum logic {ST_FILL, ST_HOLD} state_t;
  state_t state, state_nxt;

  logic [DW-1:0]           acc_data;
  logic [CW-1:0]           acc_cnt;
  logic [SEQ_PER_BEAT-1:0] acc_keep;
  logic                    acc_last;
  logic                    acc_delim;

  logic [DW-1:0]           beat_data;
  logic [SEQ_PER_BEAT-1:0] beat_keep;
  logic                    accept;
  logic                    slot_free;
  logic                    lane_full;
  logic                    complete;
  logic                    load_hold;
  logic                    load_beat;
  int                      lane_lo;

  assign accept    = in_valid & in_ready;
  assign slot_free = !out_valid | out_ready;
  assign lane_full = (acc_cnt == CW'(SEQ_PER_BEAT - 1));
  assign complete  = accept & (lane_full | in_end_of_job);

  // Accumulator contents with the incoming word already placed in its lane
  always_comb begin
    lane_lo   = int'(acc_cnt) * 64;
    beat_data = acc_data;
    beat_data[lane_lo +: 64] = in_seq;
    beat_keep = '0;
    for (int k = 0; k < SEQ_PER_BEAT; k++) begin
      beat_keep[k] = (k <= int'(acc_cnt));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: if (complete && !slot_free) state_nxt = ST_HOLD;
      ST_HOLD: if (slot_free)              state_nxt = ST_FILL;
      default:                             state_nxt = ST_FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_FILL);
    load_hold = (state == ST_HOLD) & slot_free;
    load_beat = complete & slot_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_data       <= '0;
      acc_cnt        <= '0;
      acc_keep       <= '0;
      acc_last       <= 1'b0;
      acc_delim      <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_keep       <= '0;
      out_last       <= 1'b0;
      out_delim      <= 1'b0;
      stat_seq_count <= '0;
      stat_job_count <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (load_hold) begin
        out_valid <= 1'b1;
        out_data  <= acc_data;
        out_keep  <= acc_keep;
        out_last  <= acc_last;
        out_delim <= acc_delim;
        acc_data  <= '0;
        acc_cnt   <= '0;
      end else if (load_beat) begin
        out_valid <= 1'b1;
        out_data  <= beat_data;
        out_keep  <= beat_keep;
        out_last  <= in_end_of_job;
        out_delim <= in_end_of_job & in_delim;
        acc_data  <= '0;
        acc_cnt   <= '0;
      end else if (complete) begin
        acc_data  <= beat_data;
        acc_keep  <= beat_keep;
        acc_last  <= in_end_of_job;
        acc_delim <= in_end_of_job & in_delim;
        acc_cnt   <= '0;
      end else if (accept) begin
        acc_data  <= beat_data;
        acc_cnt   <= acc_cnt + CW'(1);
      end

      if (accept) begin
        stat_seq_count <= stat_seq_count + 32'd1;
        if (in_end_of_job) stat_job_count <= stat_job_count + 16'd1;
      end
    end
  end

  // Every word from the sequence packer carries its valid flag in bit 0
  a_seq_flag: assert property (@(posedge clk) disable iff (rst) in_valid |-> in_seq[0]);

endmodule

// File: tb/tb_job_seq_beat_pack.sv
// Directed bench for job_seq_beat_pack: hand-checked beats plus a reference scoreboard on every output transfer.
module tb_job_seq_beat_pack;

  localparam int N  = 4;
  localparam int DW = 64 * N;
  localparam int MAXS = 10000;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [63:0]   in_seq;
  logic          in_end_of_job;
  logic          in_delim;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [N-1:0]  out_keep;
  logic          out_last;
  logic          out_delim;
  logic          out_ready;
  logic [31:0]   stat_seq_count;
  logic [15:0]   stat_job_count;

  always #5 clk = ~clk;

  job_seq_beat_pack #(.SEQ_PER_BEAT(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_seq         (in_seq),
    .in_end_of_job  (in_end_of_job),
    .in_delim       (in_delim),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_keep       (out_keep),
    .out_last       (out_last),
    .out_delim      (out_delim),
    .out_ready      (out_ready),
    .stat_seq_count (stat_seq_count),
    .stat_job_count (stat_job_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mk(input int t, input int i);
    return {8'(t), 24'h5A5A5A, 31'(i), 1'b1};
  endfunction

  // Reference scoreboard
  typedef struct {
    logic [DW-1:0] data;
    logic [N-1:0]  keep;
    logic          last;
    logic          delim;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         b_out;
  beat_t         b_new;
  logic [DW-1:0] m_data;
  int            m_cnt;
  logic [31:0]   m_seq;
  logic [15:0]   m_job;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_data = '0;
      m_cnt  = 0;
      m_seq  = '0;
      m_job  = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_beat", DW'(1), DW'(0));
        else begin
          b_out = exp_q.pop_front();
          check("sb_data",  out_data,         b_out.data);
          check("sb_keep",  DW'(out_keep),    DW'(b_out.keep));
          check("sb_last",  DW'(out_last),    DW'(b_out.last));
          check("sb_delim", DW'(out_delim),   DW'(b_out.delim));
        end
      end
      if (in_valid && in_ready) begin
        m_data[64*m_cnt +: 64] = in_seq;
        m_cnt++;
        m_seq++;
        if (in_end_of_job) m_job++;
        if (m_cnt == N || in_end_of_job) begin
          b_new.data  = m_data;
          b_new.keep  = N'((1 << m_cnt) - 1);
          b_new.last  = in_end_of_job;
          b_new.delim = in_end_of_job & in_delim;
          exp_q.push_back(b_new);
          m_data = '0;
          m_cnt  = 0;
        end
      end
    end
  end

  logic [63:0] st_seq[MAXS];
  bit          st_eoj[MAXS];
  bit          st_delim[MAXS];

  task automatic put(input int i, input logic [63:0] s, input bit e, input bit d);
    st_seq[i] = s; st_eoj[i] = e; st_delim[i] = d;
  endtask

  // mode 0: out_ready=1; 1: out_ready=0 for 10 cycles then 1; 2: random both; 3: out_ready=0
  // Entered and left #1 after a rising edge.
  task automatic run(input int n, input int mode, input bit drain);
    int  idx = 0;
    int  c = 0;
    int  budget = n * 8 + 200;
    bit  acc;
    bit  done = 0;
    while (c < budget) begin
      if (idx < n) begin
        in_valid      = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        in_seq        = st_seq[idx];
        in_end_of_job = st_eoj[idx];
        in_delim      = st_delim[idx];
      end else begin
        in_valid = 1'b0;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c >= 10);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      @(negedge clk);
      acc = in_valid && in_ready;
      if (mode == 1 && (c == 8 || c == 9)) begin
        check("t4_in_ready_low", DW'(in_ready), DW'(0));
        check("t4_out_valid",    DW'(out_valid), DW'(1));
        check("t4_data_stable",  out_data, {mk(4, 3), mk(4, 2), mk(4, 1), mk(4, 0)});
      end
      if (mode == 1 && c == 11) check("t4_in_ready_back", DW'(in_ready), DW'(1));
      @(posedge clk);
      #1;
      if (acc) idx++;
      c++;
      if (idx == n && (!drain || (!out_valid && in_ready && exp_q.size() == 0))) begin
        done = 1;
        break;
      end
    end
    in_valid = 1'b0;
    check("timeout", DW'(done), DW'(1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_seq = 64'h1; in_end_of_job = 1'b0; in_delim = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  DW'(in_ready),       DW'(1));
    check("rst_out_valid", DW'(out_valid),      DW'(0));
    check("rst_out_data",  out_data,            DW'(0));
    check("rst_keep_last", DW'({out_keep, out_last, out_delim}), DW'(0));
    check("rst_counters",  DW'({stat_seq_count, stat_job_count}), DW'(0));
    rst = 1'b0;

    // T1: full beat, no eoj, visible one cycle after D
    for (int i = 0; i < 4; i++) put(i, mk(1, i), 0, 0);
    run(4, 0, 0);
    check("t1_valid", DW'(out_valid), DW'(1));
    check("t1_keep",  DW'(out_keep),  DW'(4'b1111));
    check("t1_data",  out_data, {mk(1, 3), mk(1, 2), mk(1, 1), mk(1, 0)});
    check("t1_last",  DW'(out_last),  DW'(0));
    check("t1_seq_count", DW'(stat_seq_count), DW'(4));
    run(0, 0, 1);

    // T2: 2 seqs, eoj+delim on the second
    put(0, mk(2, 0), 0, 1);
    put(1, mk(2, 1), 1, 1);
    run(2, 0, 0);
    check("t2_keep",  DW'(out_keep),  DW'(4'b0011));
    check("t2_lanes", out_data, {128'b0, mk(2, 1), mk(2, 0)});
    check("t2_last",  DW'(out_last),  DW'(1));
    check("t2_delim", DW'(out_delim), DW'(1));
    check("t2_job_count", DW'(stat_job_count), DW'(1));
    run(0, 0, 1);

    // T3: eoj in last lane, then a single-seq job with delim=0
    for (int i = 0; i < 3; i++) put(i, mk(3, i), 0, 0);
    put(3, mk(3, 3), 1, 1);
    put(4, mk(3, 4), 1, 0);
    run(5, 0, 0);
    check("t3_keep",  DW'(out_keep),  DW'(4'b0001));
    check("t3_data",  out_data, DW'(mk(3, 4)));
    check("t3_last",  DW'(out_last),  DW'(1));
    check("t3_delim", DW'(out_delim), DW'(0));
    check("t3_counts", DW'({stat_seq_count, stat_job_count}), DW'({32'd11, 16'd3}));
    run(0, 0, 1);

    // T4: back-pressure with a held beat
    for (int i = 0; i < 12; i++) put(i, mk(4, i), 0, 0);
    run(12, 1, 1);
    check("t4_seq_count", DW'(stat_seq_count), DW'(23));

    // T5: random handshakes and job boundaries
    for (int i = 0; i < MAXS; i++)
      put(i, mk(5, i), ($urandom_range(0, 4) == 0) || (i == MAXS - 1), 1'($urandom_range(0, 1)));
    run(MAXS, 2, 1);
    check("t5_seq_count", DW'(stat_seq_count), DW'(m_seq));
    check("t5_job_count", DW'(stat_job_count), DW'(m_job));
    check("t5_drained",   DW'(exp_q.size()),   DW'(0));

    // T6: reset with a pending beat and 3 lanes filled
    for (int i = 0; i < 7; i++) put(i, mk(6, i), 0, 0);
    run(7, 3, 0);
    check("t6_pending", DW'(out_valid), DW'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_in_ready",  DW'(in_ready),  DW'(1));
    check("t6_out_valid", DW'(out_valid), DW'(0));
    check("t6_out_data",  out_data,       DW'(0));
    check("t6_fields",    DW'({out_keep, out_last, out_delim}), DW'(0));
    check("t6_counters",  DW'({stat_seq_count, stat_job_count}), DW'(0));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) put(i, mk(6, 10 + i), 0, 0);
    run(4, 0, 0);
    check("t6_keep", DW'(out_keep), DW'(4'b1111));
    check("t6_data", out_data, {mk(6, 13), mk(6, 12), mk(6, 11), mk(6, 10)});
    check("t6_seq_count", DW'(stat_seq_count), DW'(4));
    run(0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
